// File: rtl/div_rem_sequencer_pkg.sv
// Shared definitions for the RV32M divide/remainder sequencer: ALU select codes and FSM encoding.
// Any unit that must recognise a divide select code imports this package.
package div_rem_sequencer_pkg;

    localparam logic [4:0] AluDiv  = 5'b01100;
    localparam logic [4:0] AluRem  = 5'b01101;
    localparam logic [4:0] AluDivu = 5'b01110;
    localparam logic [4:0] AluRemu = 5'b01111;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StCalc  = 2'b01,
        StFixup = 2'b10
    } div_state_e;

    function automatic logic is_div_sel(input logic [4:0] sel);
        return (sel == AluDiv) || (sel == AluRem) || (sel == AluDivu) || (sel == AluRemu);
    endfunction

    function automatic logic is_rem_sel(input logic [4:0] sel);
        return (sel == AluRem) || (sel == AluRemu);
    endfunction

    function automatic logic is_unsigned_sel(input logic [4:0] sel);
        return (sel == AluDivu) || (sel == AluRemu);
    endfunction

endpackage

// File: rtl/div_rem_sequencer_div_step.sv
// One radix-2 restoring divide iteration on unsigned magnitudes.
// Relies on rem_in < divisor, which the sequencer guarantees between iterations.
module div_rem_sequencer_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          no_borrow;

    always_comb begin
        shifted   = {rem_in, quo_in[XLEN-1]};
        trial     = shifted - {1'b0, divisor};
        // With the top shifted bit set the partial remainder already exceeds any divisor.
        no_borrow = shifted[XLEN] | ~trial[XLEN];
        rem_out   = no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_out   = {quo_in[XLEN-2:0], no_borrow};
    end

endmodule

// File: rtl/div_rem_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: latches an op from EX, iterates a restoring divide
// one quotient bit per cycle, then returns the signed-corrected result with a one-cycle done pulse.
module div_rem_sequencer
    import div_rem_sequencer_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [4:0]       select,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int unsigned     CntW   = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;

    logic             signed_op;
    logic             div_zero;
    logic             overflow;
    logic [XLEN-1:0]  abs_a;
    logic [XLEN-1:0]  abs_b;
    logic [XLEN-1:0]  step_rem;
    logic [XLEN-1:0]  step_quo;

    div_rem_sequencer_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        tag_d     = tag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        signed_op = !is_unsigned_sel(select);
        div_zero  = (operand_b == '0);
        overflow  = signed_op && (operand_a == MinNeg) && (operand_b == '1);
        abs_a     = (signed_op && operand_a[XLEN-1]) ? -operand_a : operand_a;
        abs_b     = (signed_op && operand_b[XLEN-1]) ? -operand_b : operand_b;

        unique case (state_q)
            StIdle: begin
                if (start && !flush && is_div_sel(select)) begin
                    is_rem_d = is_rem_sel(select);
                    tag_d    = tag_in;
                    cnt_d    = '0;
                    // Special cases preload the final quotient/remainder and skip iteration.
                    if (div_zero) begin
                        quo_d     = '1;
                        rem_d     = operand_a;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = StFixup;
                    end else if (overflow) begin
                        quo_d     = MinNeg;
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = StFixup;
                    end else begin
                        quo_d     = abs_a;
                        rem_d     = '0;
                        dvsr_d    = abs_b;
                        neg_quo_d = signed_op && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                        neg_rem_d = signed_op && operand_a[XLEN-1];
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        state_d = StFixup;
                    end
                end
            end
            StFixup: begin
                state_d = StIdle;
                if (!flush) begin
                    if (is_rem_q) begin
                        result_d = neg_rem_q ? -rem_q : rem_q;
                    end else begin
                        result_d = neg_quo_q ? -quo_q : quo_q;
                    end
                    tag_out_d = tag_q;
                    done_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            tag_q     <= tag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign result  = result_q;
    assign tag_out = tag_out_q;

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Scoreboard bench for div_rem_sequencer: expected results are queued at issue time
// and popped when done pulses; each scenario task does its own comparisons.
module tb_div_rem_sequencer;

    localparam logic [4:0] SelDiv  = 5'b01100;
    localparam logic [4:0] SelRem  = 5'b01101;
    localparam logic [4:0] SelDivu = 5'b01110;
    localparam logic [4:0] SelRemu = 5'b01111;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [4:0]  select;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  tag_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_res = '0;
    logic [4:0]  last_tag = '0;

    always #5 CLK = ~CLK;

    div_rem_sequencer #(
        .XLEN  (32),
        .TAG_W (5)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .select    (select),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .tag_in    (tag_in),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .tag_out   (tag_out)
    );

    function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        sa   = a;
        sb_v = b;
        if (b == 32'd0) return (sel == SelDiv || sel == SelDivu) ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            if (sel == SelDiv) return 32'h8000_0000;
            if (sel == SelRem) return 32'd0;
        end
        case (sel)
            SelDiv:  return sa / sb_v;
            SelRem:  return sa % sb_v;
            SelDivu: return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] sel, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'd0) return 1;
        if ((sel == SelDiv || sel == SelRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 33;
    endfunction

    task automatic push_exp(input logic [31:0] r, input logic [4:0] t, input int l);
        exp_t e;
        e.res = r;
        e.tag = t;
        e.lat = l;
        sb.push_back(e);
    endtask

    // Drives a request for exactly one edge; returns #1 after that (accept) edge.
    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg);
        start     = 1'b1;
        select    = sel;
        operand_a = a;
        operand_b = b;
        tag_in    = tg;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_edges, output int edges, output bit got,
                             output logic [31:0] res, output logic [4:0] tg);
        edges = 0;
        got   = 1'b0;
        res   = 'x;
        tg    = 'x;
        while (!got && edges < max_edges) begin
            @(posedge CLK);
            #1;
            edges++;
            if (done === 1'b1) begin
                got = 1'b1;
                res = result;
                tg  = tag_out;
            end
        end
    endtask

    task automatic test_reset;
        RESET     = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        select    = '0;
        operand_a = '0;
        operand_b = '0;
        tag_in    = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({busy, done, result, tag_out} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h tag=%0d, want all 0",
                     busy, done, result, tag_out);
        end
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_invalid_select;
        int dcnt;
        issue(5'b00000, 32'd10, 32'd2, 5'd1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_sel_add: got busy=%b, want 0", busy);
        end
        issue(5'b01011, 32'd10, 32'd2, 5'd1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_sel_01011: got busy=%b, want 0", busy);
        end
        dcnt = 0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (done === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL invalid_sel_done: got %0d done cycles, want 0", dcnt);
        end
    endtask

    task automatic test_div_latency;
        int          edges;
        int          busy_cnt;
        bit          got;
        logic        busy_at_done;
        logic [31:0] r;
        logic [4:0]  t;
        exp_t        e;
        push_exp(32'hFFFF_FFFA, 5'd1, 33);
        issue(SelDiv, 32'hFFFF_FFEC, 32'd3, 5'd1);
        busy_cnt     = (busy === 1'b1) ? 1 : 0;
        edges        = 0;
        got          = 1'b0;
        busy_at_done = 1'bx;
        r            = 'x;
        t            = 'x;
        while (!got && edges < 40) begin
            @(posedge CLK);
            #1;
            edges++;
            if (done === 1'b1) begin
                got          = 1'b1;
                r            = result;
                t            = tag_out;
                busy_at_done = busy;
            end else if (busy === 1'b1) begin
                busy_cnt++;
            end
        end
        e = sb.pop_front();
        last_res = e.res;
        last_tag = e.tag;
        checks++;
        if (!got || edges != e.lat) begin
            errors++;
            $display("FAIL div_latency: got=%0b after %0d edges, want done after %0d",
                     got, edges, e.lat);
        end
        checks++;
        if (busy_cnt != 33) begin
            errors++;
            $display("FAIL div_busy_cycles: got %0d busy cycles, want 33", busy_cnt);
        end
        checks++;
        if (busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL div_busy_in_done: got %b, want 0", busy_at_done);
        end
        checks++;
        if (r !== e.res || t !== e.tag) begin
            errors++;
            $display("FAIL div_result: got %h tag %0d, want %h tag %0d", r, t, e.res, e.tag);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse: got done=%b one cycle later, want 0", done);
        end
    endtask

    // Table-driven ops; exp_r holds hand-derived constants checked against the returned value.
    task automatic test_op_table(input string grp, input int n, input logic [4:0] sels[6],
                                 input logic [31:0] as[6], input logic [31:0] bs[6],
                                 input logic [31:0] exp_r[6], input int lats[6]);
        int          edges;
        bit          got;
        logic [31:0] r;
        logic [4:0]  t;
        exp_t        e;
        for (int i = 0; i < n; i++) begin
            push_exp(exp_r[i], 5'(10 + i), lats[i]);
            issue(sels[i], as[i], bs[i], 5'(10 + i));
            wait_done(40, edges, got, r, t);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_%0d_scoreboard: queue empty, want one entry", grp, i);
            end else begin
                e = sb.pop_front();
                last_res = e.res;
                last_tag = e.tag;
                checks++;
                if (!got || edges != e.lat) begin
                    errors++;
                    $display("FAIL %s_%0d_latency: got=%0b after %0d edges, want %0d",
                             grp, i, got, edges, e.lat);
                end
                checks++;
                if (r !== e.res) begin
                    errors++;
                    $display("FAIL %s_%0d_result: got %h, want %h", grp, i, r, e.res);
                end
                checks++;
                if (t !== e.tag) begin
                    errors++;
                    $display("FAIL %s_%0d_tag: got %0d, want %0d", grp, i, t, e.tag);
                end
            end
        end
    endtask

    task automatic test_signed_unsigned;
        logic [4:0]  sels[6];
        logic [31:0] as[6];
        logic [31:0] bs[6];
        logic [31:0] er[6];
        int          lats[6];
        sels = '{SelRem, SelRemu, SelDivu, SelDiv, SelRem, SelDiv};
        as   = '{32'hFFFF_FFEC, 32'd20, 32'hFFFF_FFFF, 32'd20, 32'd20, 32'hFFFF_FFEC};
        bs   = '{32'd3, 32'd3, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
        er   = '{32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFA, 32'd2, 32'd6};
        lats = '{33, 33, 33, 33, 33, 33};
        test_op_table("sign", 6, sels, as, bs, er, lats);
    endtask

    task automatic test_special_cases;
        logic [4:0]  sels[6];
        logic [31:0] as[6];
        logic [31:0] bs[6];
        logic [31:0] er[6];
        int          lats[6];
        sels = '{SelDiv, SelRem, SelDivu, SelRemu, SelRem, SelDivu};
        as   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd7};
        bs   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        er   = '{32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF};
        lats = '{1, 1, 33, 33, 1, 1};
        test_op_table("special", 6, sels, as, bs, er, lats);
    endtask

    task automatic test_flush;
        int dcnt;
        issue(SelDiv, 32'd100, 32'd7, 5'd9);
        repeat (9) @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_busy: got busy=%b at iteration 9, want 1", busy);
        end
        flush     = 1'b1;
        start     = 1'b1;
        select    = SelRemu;
        operand_a = 32'd20;
        operand_b = 32'd3;
        tag_in    = 5'd20;
        @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_to_idle: got busy=%b after flushed iteration 10, want 0", busy);
        end
        @(posedge CLK);
        #1;
        flush = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_start: got busy=%b after start+flush in idle, want 0",
                     busy);
        end
        dcnt = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (done === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL flush_no_done: got %0d done cycles, want 0", dcnt);
        end
        checks++;
        if (result !== last_res || tag_out !== last_tag) begin
            errors++;
            $display("FAIL flush_holds_result: got %h tag %0d, want %h tag %0d",
                     result, tag_out, last_res, last_tag);
        end
    endtask

    task automatic test_async_reset;
        issue(SelDiv, 32'd1000, 32'd3, 5'd12);
        repeat (5) @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || tag_out !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h tag=%0d, want all 0",
                     busy, done, result, tag_out);
        end
        @(negedge CLK);
        RESET    = 1'b0;
        last_res = '0;
        last_tag = '0;
        @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_idle: got busy=%b after release, want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 7;
        logic [4:0]  sels[N];
        logic [31:0] as[N];
        logic [31:0] bs[N];
        logic [4:0]  tags[N];
        int          edges;
        bit          got;
        logic [31:0] r;
        logic [4:0]  t;
        exp_t        e;
        sels[0] = SelDiv;  as[0] = 32'd100; bs[0] = 32'd7; tags[0] = 5'd6;
        sels[1] = SelRemu; as[1] = 32'd20;  bs[1] = 32'd3; tags[1] = 5'd7;
        for (int i = 2; i < N; i++) begin
            sels[i] = SelDiv + 5'($urandom_range(0, 3));
            as[i]   = $urandom;
            bs[i]   = (i == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            tags[i] = 5'($urandom_range(0, 31));
        end
        push_exp(model(sels[0], as[0], bs[0]), tags[0], model_lat(sels[0], as[0], bs[0]));
        issue(sels[0], as[0], bs[0], tags[0]);
        for (int i = 0; i < N; i++) begin
            wait_done(40, edges, got, r, t);
            e = sb.pop_front();
            checks++;
            if (!got || edges != e.lat) begin
                errors++;
                $display("FAIL b2b_%0d_latency: got=%0b after %0d edges, want %0d",
                         i, got, edges, e.lat);
            end
            checks++;
            if (r !== e.res || t !== e.tag) begin
                errors++;
                $display("FAIL b2b_%0d_result: got %h tag %0d, want %h tag %0d",
                         i, r, t, e.res, e.tag);
            end
            if (i < N - 1) begin
                push_exp(model(sels[i+1], as[i+1], bs[i+1]), tags[i+1],
                         model_lat(sels[i+1], as[i+1], bs[i+1]));
                issue(sels[i+1], as[i+1], bs[i+1], tags[i+1]);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_%0d_accept: got busy=%b after start in done cycle, want 1",
                             i + 1, busy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_invalid_select();
        test_div_latency();
        test_signed_unsigned();
        test_special_cases();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
